req_arbiter_7: RTL

Round-robin arbiter that shares one 7-way resource among 7 requesters and drives the shared 3-bit-to-7-line decoder. The block issues a binary grant code in the range 1–7, with 0 meaning no grant. It also outputs the matching one-hot grant, enforces a maximum tenure per grant, and inserts dead cycles between grants so that no two grants overlap.

---
 rtl/req_arbiter_7.sv | 69 ++++++
 1 files changed

// File: rtl/req_arbiter_7.sv
// req_arbiter_7: round-robin arbiter for 7 requesters; ports i_clk/i_rst (sync, active-high), i_en, i_req[6:0] in; o_code (1-7, 0 = none), o_gnt one-hot, o_busy, o_timeout out
module req_arbiter_7 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [6:0] i_req,
  output logic [2:0] o_code,
  output logic [6:0] o_gnt,
  output logic       o_busy,
  output logic       o_timeout
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [2:0] r_last, win;
  logic [HW-1:0] r_hold;
  logic grab, tmo_n, own;
  assign own = |(o_gnt & i_req);
  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 1; i--)
      if (i_req[3'((int'(r_last) + i - 1) % 7)]) win = 3'((int'(r_last) + i - 1) % 7 + 1);
  end
  always_comb begin
    state_n = state;
    grab = 1'b0;
    tmo_n = 1'b0;
    case (state)
      IDLE: begin
        grab = i_en && |i_req;
        state_n = grab ? GRANT : IDLE;
      end
      GRANT: begin
        state_n = (!own || r_hold == HOLD_MAX) ? RELEASE : GRANT;
        tmo_n = own && r_hold == HOLD_MAX;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_code <= 3'd0;
      o_gnt <= 7'd0;
      o_busy <= 1'b0;
      o_timeout <= 1'b0;
      r_last <= 3'd7;
      r_hold <= '0;
    end else begin
      state <= state_n;
      o_busy <= state_n == GRANT;
      o_timeout <= tmo_n;
      if (grab) begin
        o_code <= win;
        o_gnt <= 7'd1 << (win - 3'd1);
        r_last <= win;
        r_hold <= HW'(1);
      end else if (state_n != GRANT) begin
        o_code <= 3'd0;
        o_gnt <= 7'd0;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end
endmodule
